control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: WORD, 16, datapath width; the instruction field occupies din[WORD-1:WORD-9].
REQ-002 Ports, one per line:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- run  in  1  start request; sampled in T0.
- din  in  WORD  instruction word (T0), immediate source (T1).
- ir_in  out  1  instruction-register load strobe.
- r_in  out  8  one-hot register load enables.
- r_out  out  8  one-hot register bus-drive enables.
- a_in  out  1  ALU A-operand register load.
- g_in  out  1  ALU result register G load.
- g_out  out  1  G drives bus.
- din_out  out  1  din drives bus.
- alu_op  out  2  ALU operation: 00 NOP, 01 ADD, 10 SUB.
- done  out  1  one-cycle instruction-complete pulse.
- halted  out  1  processor halted (0 when CU_HALT_EN is undefined).

Function
REQ-003 Instruction format: I[2:0]=din[WORD-1:WORD-3], X=din[WORD-4:WORD-6], Y=din[WORD-7:WORD-9]; captured into an internal 9-bit IR on the T0->T1 edge.
REQ-004 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 111 halt (CU_HALT_EN only); all others execute as NOP.
REQ-005 FSM states: T0, T1, T2, T3, HALT (HALT exists only with CU_HALT_EN); state is registered; outputs are combinational from state and IR.
REQ-006 T0: ir_in=run; if run=1 go to T1, else stay in T0; all other outputs are 0.
REQ-007 T1 mv: r_out[Y], r_in[X], done; go to T0.
REQ-008 T1 mvi: din_out, r_in[X], done; go to T0.
REQ-009 T1 add/sub: r_out[X], a_in; go to T2.
REQ-010 T2 add/sub: r_out[Y], g_in, alu_op=01 (add) or 10 (sub); go to T3.
REQ-011 T3 add/sub: g_out, r_in[X], done; go to T0.
REQ-012 T1 NOP: done only; go to T0.
REQ-013 Latency from the T0 run edge to done: mv/mvi/NOP 1 cycle; add/sub 3 cycles.
REQ-014 At most one of r_out, g_out and din_out shall be nonzero in any cycle, and r_out shall be one-hot or zero.
REQ-015 alu_op shall be 00 in every state except T2.
REQ-016 run is ignored outside T0; deasserting run mid-instruction shall not abort the instruction.
REQ-017 X==Y is legal and shall produce the same sequence as any other register pair.

Reset
REQ-018 rst=1 at a clk edge sets state=T0 and IR=0 in any state, including mid-instruction and HALT.
REQ-019 While in reset and in the cycle after it, every output is 0; rst takes priority over run.

Configuration
REQ-020 With macro CU_HALT_EN defined: opcode 111 in T1 goes to HALT, and HALT holds halted=1 with all other outputs 0 until rst.
REQ-021 With CU_HALT_EN undefined: opcode 111 is NOP, and halted is tied to 0.

Structure
REQ-022 A shared package cpu_pkg holds WORD, ALU_NOP/ALU_ADD/ALU_SUB, the opcode constants and the state enumeration; the ALU and testbenches import the same constants.
REQ-023 A sub-module dec3to8 (3-bit to one-hot 8-bit, with enable) generates r_in and r_out.

Verification
REQ-024 The bench shall cover these directed scenarios:
- Reset: rst=1 for 2 cycles with run=1 -> all outputs 0; after release, state is T0.
- mvi R0: din=16'h2000, run=1 in T0 -> next cycle ir_in pulse; in T1 din_out=1, r_in=8'b00000001, done=1; then T0.
- add R1,R2: din=16'h4500 -> T1 r_out=8'b00000010 with a_in; T2 r_out=8'b00000100, alu_op=01, g_in; T3 g_out, r_in=8'b00000010, done.
- sub R3,R3: din=16'h6D80 with run dropped in T2 -> T3 still completes: g_out, r_in=8'b00001000, done; T2 has alu_op=10.
- Reset mid-op: rst=1 during T2 of add -> next cycle all outputs 0, state T0, no done pulse.
- Halt: din=16'hE000 -> with CU_HALT_EN, halted=1 persists and run is ignored until rst; without it, done is pulsed in T1, then T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the simple CPU: datapath width, ALU ops, opcodes and control states.
// The HALT state exists only when CU_HALT_EN is defined.
package cpu_pkg;

  localparam int WORD = 16;
  localparam int IR_W = 9;

  localparam logic [1:0] ALU_NOP = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

`ifdef CU_HALT_EN
  typedef enum logic [2:0] {S_T0, S_T1, S_T2, S_T3, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_T0, S_T1, S_T2, S_T3} state_t;
`endif

  function automatic logic [1:0] alu_sel(input logic [2:0] op);
    return (op == OP_SUB) ? ALU_SUB : ALU_ADD;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to one-hot 8-bit decoder with enable; all zeros when disabled.
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit sequencing mv/mvi/add/sub through states T0..T3.
// Define CU_HALT_EN to make opcode 111 enter a HALT state held until reset.
import cpu_pkg::*;

module control_unit #(
  parameter int WORD = cpu_pkg::WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [WORD-1:0] din,
  output logic            ir_in,
  output logic [7:0]      r_in,
  output logic [7:0]      r_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            din_out,
  output logic [1:0]      alu_op,
  output logic            done,
  output logic            halted
);

  state_t           state;
  state_t           next;
  logic [IR_W-1:0]  ir;
  logic [2:0]       opcode;
  logic [2:0]       rx;
  logic [2:0]       ry;

  logic [2:0]       in_sel;
  logic             in_en;
  logic [2:0]       out_sel;
  logic             out_en;
  logic             halt_flag;
  logic             din_unused;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  // Only the top nine bits of din form the instruction; the rest is immediate data.
  assign din_unused = ^din[WORD-IR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_T0;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_T0 && run) ir <= din[WORD-1 -: IR_W];
    end
  end

  always_comb begin
    next      = state;
    ir_in     = 1'b0;
    in_sel    = 3'd0;
    in_en     = 1'b0;
    out_sel   = 3'd0;
    out_en    = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    g_out     = 1'b0;
    din_out   = 1'b0;
    alu_op    = ALU_NOP;
    done      = 1'b0;
    halt_flag = 1'b0;

    case (state)
      S_T0: begin
        ir_in = run;
        next  = run ? S_T1 : S_T0;
      end
      S_T1: begin
        next = S_T0;
        case (opcode)
          OP_MV: begin
            out_en  = 1'b1;
            out_sel = ry;
            in_en   = 1'b1;
            in_sel  = rx;
            done    = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            in_en   = 1'b1;
            in_sel  = rx;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            out_en  = 1'b1;
            out_sel = rx;
            a_in    = 1'b1;
            next    = S_T2;
          end
`ifdef CU_HALT_EN
          OP_HALT: next = S_HALT;
`endif
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        out_en  = 1'b1;
        out_sel = ry;
        g_in    = 1'b1;
        alu_op  = alu_sel(opcode);
        next    = S_T3;
      end
      S_T3: begin
        g_out  = 1'b1;
        in_en  = 1'b1;
        in_sel = rx;
        done   = 1'b1;
        next   = S_T0;
      end
`ifdef CU_HALT_EN
      S_HALT: begin
        halt_flag = 1'b1;
        next      = S_HALT;
      end
`endif
      default: next = S_T0;
    endcase

    // Reset silences every strobe in the same cycle, whatever state is still held.
    if (rst) begin
      ir_in     = 1'b0;
      in_en     = 1'b0;
      out_en    = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      g_out     = 1'b0;
      din_out   = 1'b0;
      alu_op    = ALU_NOP;
      done      = 1'b0;
      halt_flag = 1'b0;
    end
  end

  assign halted = halt_flag;

  dec3to8 u_dec_in (
    .sel    (in_sel),
    .en     (in_en),
    .onehot (r_in)
  );

  dec3to8 u_dec_out (
    .sel    (out_sel),
    .en     (out_en),
    .onehot (r_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model of the per-cycle control outputs.
module tb_control_unit;
  import cpu_pkg::*;

  localparam int OW = 25;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic [WORD-1:0] din;
  logic            ir_in, a_in, g_in, g_out, din_out, done, halted;
  logic [7:0]      r_in, r_out;
  logic [1:0]      alu_op;

  logic [OW-1:0]   obs;
  logic [OW-1:0]   exp_q[$];
  int              passed = 0;
  int              total  = 0;

  control_unit #(.WORD(WORD)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .din_out (din_out),
    .alu_op  (alu_op),
    .done    (done),
    .halted  (halted)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign obs = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, done, halted};

  function automatic logic [OW-1:0] ov(input logic ir, input logic [7:0] ri, input logic [7:0] ro,
                                       input logic a, input logic g, input logic go, input logic dout,
                                       input logic [1:0] op, input logic dn, input logic h);
    return {ir, ri, ro, a, g, go, dout, op, dn, h};
  endfunction

  // Reference model: expected output vector for each cycle of one instruction, starting at the T0 run cycle.
  task automatic push_expected(input logic [WORD-1:0] w);
    logic [2:0] op, x, y;
    logic [7:0] rx, ry;
    op = w[WORD-1 -: 3];
    x  = w[WORD-4 -: 3];
    y  = w[WORD-7 -: 3];
    rx = 8'd1 << x;
    ry = 8'd1 << y;
    exp_q.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    if (op == OP_MV) begin
      exp_q.push_back(ov(0, rx, ry, 0, 0, 0, 0, ALU_NOP, 1, 0));
    end else if (op == OP_MVI) begin
      exp_q.push_back(ov(0, rx, 0, 0, 0, 0, 1, ALU_NOP, 1, 0));
    end else if (op == OP_ADD || op == OP_SUB) begin
      exp_q.push_back(ov(0, 0, rx, 1, 0, 0, 0, ALU_NOP, 0, 0));
      exp_q.push_back(ov(0, 0, ry, 0, 1, 0, 0, (op == OP_ADD) ? ALU_ADD : ALU_SUB, 0, 0));
      exp_q.push_back(ov(0, rx, 0, 0, 0, 1, 0, ALU_NOP, 1, 0));
    end else begin
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 1, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; din = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== '0) $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, {OW{1'b0}});
      else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b0; run = 1'b0; din = '0;
    @(negedge clk);
    total++;
    if (obs !== '0) $display("FAIL reset_release: got %h expected %h", obs, {OW{1'b0}});
    else passed++;
    total++;
    if (dut.state !== S_T0) $display("FAIL reset_state: got %0d expected %0d", dut.state, S_T0);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mvi();
    logic [OW-1:0] e[$];
    e.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 8'h01, 0, 0, 0, 0, 1, ALU_NOP, 1, 0));
    e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    for (int i = 0; i < 3; i++) begin
      run = (i == 0); din = (i == 0) ? 16'h2000 : 16'h1234;
      @(negedge clk);
      total++;
      if (obs !== e[i]) $display("FAIL mvi cycle %0d: got %h expected %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    logic [OW-1:0] e[$];
    e.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 0, 8'h02, 1, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 0, 8'h04, 0, 1, 0, 0, ALU_ADD, 0, 0));
    e.push_back(ov(0, 8'h02, 0, 0, 0, 1, 0, ALU_NOP, 1, 0));
    e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    for (int i = 0; i < 5; i++) begin
      run = (i == 0); din = (i == 0) ? 16'h4500 : '0;
      @(negedge clk);
      total++;
      if (obs !== e[i]) $display("FAIL add cycle %0d: got %h expected %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sub_run_drop();
    logic [OW-1:0] e[$];
    logic          runs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 0, 8'h08, 1, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 0, 8'h08, 0, 1, 0, 0, ALU_SUB, 0, 0));
    e.push_back(ov(0, 8'h08, 0, 0, 0, 1, 0, ALU_NOP, 1, 0));
    e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    for (int i = 0; i < 5; i++) begin
      run = runs[i]; din = 16'h6D80;
      @(negedge clk);
      total++;
      if (obs !== e[i]) $display("FAIL sub_run_drop cycle %0d: got %h expected %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [OW-1:0] e[$];
    e.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    e.push_back(ov(0, 0, 8'h02, 1, 0, 0, 0, ALU_NOP, 0, 0));
    for (int i = 0; i < 2; i++) begin
      run = (i == 0); din = 16'h4500;
      @(negedge clk);
      total++;
      if (obs !== e[i]) $display("FAIL reset_mid_op lead cycle %0d: got %h expected %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b1; run = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== '0) $display("FAIL reset_mid_op in_reset: got %h expected %h", obs, {OW{1'b0}});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== '0) $display("FAIL reset_mid_op after cycle %0d: got %h expected %h", i, obs, {OW{1'b0}});
      else passed++;
      if (i == 0) begin
        total++;
        if (dut.state !== S_T0) $display("FAIL reset_mid_op state: got %0d expected %0d", dut.state, S_T0);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [OW-1:0] e[$];
    int            n;
    e.push_back(ov(1, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
`ifdef CU_HALT_EN
    e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    for (int k = 0; k < 4; k++) e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 1));
`else
    e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 1, 0));
    for (int k = 0; k < 4; k++) e.push_back(ov(0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
`endif
    n = e.size();
    for (int i = 0; i < n; i++) begin
`ifdef CU_HALT_EN
      run = 1'b1;
`else
      run = (i == 0);
`endif
      din = 16'hE000;
      @(negedge clk);
      total++;
      if (obs !== e[i]) $display("FAIL halt cycle %0d: got %h expected %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== '0) $display("FAIL halt_cleared: got %h expected %h", obs, {OW{1'b0}});
    else passed++;
    @(posedge clk); #1;
  endtask

  // Random instructions with random idle gaps and random run noise during execution.
  task automatic test_random(input int count, input int max_idle);
    logic [WORD-1:0] w;
    logic [OW-1:0]   ev;
    int              idle, n;
    for (int t = 0; t < count; t++) begin
      idle = $urandom_range(0, max_idle);
      for (int k = 0; k < idle; k++) exp_q.push_back('0);
      w = WORD'($urandom);
`ifdef CU_HALT_EN
      if (w[WORD-1 -: 3] == OP_HALT) w[WORD-1 -: 3] = OP_MV;
`endif
      n = exp_q.size();
      push_expected(w);
      n = exp_q.size() - n;
      for (int k = 0; k < idle; k++) begin
        run = 1'b0; din = WORD'($urandom);
        @(negedge clk);
        ev = exp_q.pop_front();
        total++;
        if (obs !== ev) $display("FAIL random idle instr %0d: got %h expected %h", t, obs, ev);
        else passed++;
        @(posedge clk); #1;
      end
      for (int k = 0; k < n; k++) begin
        run = (k == 0) ? 1'b1 : 1'($urandom);
        din = (k == 0) ? w : WORD'($urandom);
        @(negedge clk);
        ev = exp_q.pop_front();
        total++;
        if (obs !== ev) $display("FAIL random instr %0d (%h) step %0d: got %h expected %h", t, w, k, obs, ev);
        else passed++;
        total++;
        if (($countones(r_out) > 1) || (int'(r_out != 0) + int'(g_out) + int'(din_out) > 1))
          $display("FAIL bus_exclusive instr %0d step %0d: got r_out=%b g_out=%b din_out=%b expected at most one driver",
                   t, k, r_out, g_out, din_out);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(12, 0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; din = '0;
    @(posedge clk); #1;
    test_reset();
    test_mvi();
    test_add();
    test_sub_run_drop();
    test_reset_mid_op();
    test_halt();
    test_back_to_back();
    test_random(40, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
